// File: rtl/vector_pkg.sv
// rtl/vector_pkg.sv - shared fixed-point types, ray-marcher scheduler constants and state encoding
//
// Purpose: Q8.24 fixed-point type used across the vector/ray-march datapath,
// helpers that derive the screen-space step and origin from a resolution,
// default constants for the 640x480 frame, and the scheduler FSM encoding.
// No ports (package).
package vector_pkg;

  typedef logic signed [31:0] fp;

  localparam int FP_FRAC = 24;

  // 2.0 in Q8.24; the screen spans 2 units vertically.
  localparam int FP_TWO = 2 << FP_FRAC;

  function automatic fp rm_step_f(input int v_res);
    return fp'(FP_TWO / v_res);
  endfunction

  function automatic fp rm_x0_f(input int h_res, input int v_res);
    return fp'(-(h_res / 2) * (FP_TWO / v_res));
  endfunction

  function automatic fp rm_y0_f(input int v_res);
    return fp'(-(v_res / 2) * (FP_TWO / v_res));
  endfunction

  localparam fp RM_STEP = rm_step_f(480);
  localparam fp RM_X0   = rm_x0_f(640, 480);
  localparam fp RM_Y0   = rm_y0_f(480);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rm_sched_state_e;

endpackage

// File: rtl/ray_lane_scheduler_coord.sv
// rtl/ray_lane_scheduler_coord.sv - raster x/y counters with Q8.24 coordinate accumulators
//
// Purpose: walks the frame in raster order, producing the screen-space
// coordinate of the current pixel by accumulation (no multipliers).
// Ports:
//   clk, rst      clock, synchronous active-low reset
//   init          load pixel (0,0): counters cleared, accumulators = origin
//   valid_in      a pixel is being offered downstream
//   ready_in      downstream accepts; valid_in && ready_in advances one pixel
//   screen_x/y    Q8.24 coordinate of the current pixel
//   last          current pixel is the final pixel of the frame
module ray_pixel_coord_gen
  import vector_pkg::*;
#(
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter fp  STEP  = RM_STEP,
  parameter fp  X0    = RM_X0,
  parameter fp  Y0    = RM_Y0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        valid_in,
  input  logic        ready_in,
  output logic [31:0] screen_x,
  output logic [31:0] screen_y,
  output logic        last
);

  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [31:0]   sx_q, sx_d;
  logic [31:0]   sy_q, sy_d;

  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    sx_d = sx_q;
    sy_d = sy_q;
    if (init) begin
      x_d  = '0;
      y_d  = '0;
      sx_d = X0;
      sy_d = Y0;
    end else if (valid_in && ready_in) begin
      if (x_q == XW'(H_RES - 1)) begin
        // Reload X0 instead of accumulating so row wraps never drift.
        x_d  = '0;
        sx_d = X0;
        sy_d = sy_q + STEP;
        y_d  = (y_q == YW'(V_RES - 1)) ? '0 : y_q + 1'b1;
      end else begin
        x_d  = x_q + 1'b1;
        sx_d = sx_q + STEP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      x_q  <= '0;
      y_q  <= '0;
      sx_q <= '0;
      sy_q <= '0;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      sx_q <= sx_d;
      sy_q <= sy_d;
    end
  end

  assign screen_x = sx_q;
  assign screen_y = sy_q;
  assign last     = (x_q == XW'(H_RES - 1)) && (y_q == YW'(V_RES - 1));

endmodule

// File: rtl/ray_lane_scheduler.sv
// rtl/ray_lane_scheduler.sv - frame pixel scheduler: round-robin lane dispatch/collect with credits
//
// Purpose: dispatches raster pixel k to lane (k mod N_LANES), limited by a
// per-lane credit count, and collects results in the same lane order so the
// video stream leaves in raster order without a reorder buffer.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   start                    begin one frame (only in IDLE)
//   screen_x/y               shared Q8.24 coordinate bus to the lanes
//   lane_valid/lane_ready    one-hot dispatch handshake
//   res_valid/res_shade      lane results, lane i at res_shade[24*i +: 24]
//   res_ready                one-hot result accept
//   shade_out/valid_out      registered RGB888 stream, ready_in backpressure
//   sof/eol                  first pixel of frame / last pixel of line
//   busy                     not IDLE
//   frame_done               one cycle after the final stream handshake
module ray_lane_scheduler
  import vector_pkg::*;
#(
  parameter int N_LANES      = 4,
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [31:0]           screen_x,
  output logic [31:0]           screen_y,
  output logic [N_LANES-1:0]    lane_valid,
  input  logic [N_LANES-1:0]    lane_ready,
  input  logic [N_LANES-1:0]    res_valid,
  input  logic [N_LANES*24-1:0] res_shade,
  output logic [N_LANES-1:0]    res_ready,
  output logic [23:0]           shade_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic                  sof,
  output logic                  eol,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int PW  = $clog2(N_LANES);
  localparam int CW  = $clog2(MAX_INFLIGHT + 1);
  localparam int OXW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int OYW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam fp  STEP = rm_step_f(V_RES);
  localparam fp  X0   = rm_x0_f(H_RES, V_RES);
  localparam fp  Y0   = rm_y0_f(V_RES);

  rm_sched_state_e state_q, state_d;
  logic [PW-1:0]   disp_ptr_q, disp_ptr_d;
  logic [PW-1:0]   col_ptr_q, col_ptr_d;
  logic [CW-1:0]   credit_q [N_LANES];
  logic [CW-1:0]   credit_d [N_LANES];
  logic [OXW-1:0]  ox_q, ox_d;
  logic [OYW-1:0]  oy_q, oy_d;
  logic            valid_q, valid_d;
  logic [23:0]     shade_q, shade_d;
  logic            sof_q, sof_d;
  logic            eol_q, eol_d;
  logic            last_q, last_d;

  logic frame_init;
  logic disp_hs;
  logic col_hs;
  logic out_hs;
  logic coord_last;

  assign frame_init = (state_q == IDLE) && start;
  assign out_hs     = valid_q && ready_in;
  assign disp_hs    = |(lane_valid & lane_ready);
  assign col_hs     = |(res_valid & res_ready);

  // Dispatch valid depends only on state, pointer and credit; credit can only
  // fall while waiting, so a raised lane_valid stays up until its handshake.
  always_comb begin
    lane_valid = '0;
    if (state_q == RUN && credit_q[disp_ptr_q] < CW'(MAX_INFLIGHT)) begin
      lane_valid[disp_ptr_q] = 1'b1;
    end
  end

  always_comb begin
    res_ready = '0;
    if ((state_q == RUN || state_q == DRAIN) && (!valid_q || ready_in)) begin
      res_ready[col_ptr_q] = 1'b1;
    end
  end

  ray_pixel_coord_gen #(
    .H_RES (H_RES),
    .V_RES (V_RES),
    .STEP  (STEP),
    .X0    (X0),
    .Y0    (Y0)
  ) u_coord (
    .clk      (clk),
    .rst      (rst),
    .init     (frame_init),
    .valid_in (|lane_valid),
    .ready_in (lane_ready[disp_ptr_q]),
    .screen_x (screen_x),
    .screen_y (screen_y),
    .last     (coord_last)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (disp_hs && coord_last) state_d = DRAIN;
      DRAIN:   if (out_hs && last_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < N_LANES; i++) begin
      credit_d[i] = credit_q[i];
      if ((disp_hs && disp_ptr_q == PW'(i)) && !(col_hs && col_ptr_q == PW'(i))) begin
        credit_d[i] = credit_q[i] + 1'b1;
      end else if (!(disp_hs && disp_ptr_q == PW'(i)) && (col_hs && col_ptr_q == PW'(i))) begin
        credit_d[i] = credit_q[i] - 1'b1;
      end
    end
  end

  always_comb begin
    disp_ptr_d = disp_ptr_q;
    col_ptr_d  = col_ptr_q;
    ox_d       = ox_q;
    oy_d       = oy_q;
    valid_d    = valid_q;
    shade_d    = shade_q;
    sof_d      = sof_q;
    eol_d      = eol_q;
    last_d     = last_q;

    if (disp_hs) disp_ptr_d = disp_ptr_q + 1'b1;

    if (out_hs) begin
      valid_d = 1'b0;
      sof_d   = 1'b0;
      eol_d   = 1'b0;
      last_d  = 1'b0;
    end

    // A new result can be loaded in the same cycle the held one leaves.
    if (col_hs) begin
      col_ptr_d = col_ptr_q + 1'b1;
      valid_d   = 1'b1;
      shade_d   = res_shade[24*col_ptr_q +: 24];
      sof_d     = (ox_q == '0) && (oy_q == '0);
      eol_d     = (ox_q == OXW'(H_RES - 1));
      last_d    = (ox_q == OXW'(H_RES - 1)) && (oy_q == OYW'(V_RES - 1));
      if (ox_q == OXW'(H_RES - 1)) begin
        ox_d = '0;
        oy_d = (oy_q == OYW'(V_RES - 1)) ? '0 : oy_q + 1'b1;
      end else begin
        ox_d = ox_q + 1'b1;
      end
    end

    if (frame_init) begin
      disp_ptr_d = '0;
      col_ptr_d  = '0;
      ox_d       = '0;
      oy_d       = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      disp_ptr_q <= '0;
      col_ptr_q  <= '0;
      ox_q       <= '0;
      oy_q       <= '0;
      valid_q    <= 1'b0;
      shade_q    <= '0;
      sof_q      <= 1'b0;
      eol_q      <= 1'b0;
      last_q     <= 1'b0;
      for (int i = 0; i < N_LANES; i++) credit_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      disp_ptr_q <= disp_ptr_d;
      col_ptr_q  <= col_ptr_d;
      ox_q       <= ox_d;
      oy_q       <= oy_d;
      valid_q    <= valid_d;
      shade_q    <= shade_d;
      sof_q      <= sof_d;
      eol_q      <= eol_d;
      last_q     <= last_d;
      for (int i = 0; i < N_LANES; i++) credit_q[i] <= credit_d[i];
    end
  end

  assign shade_out  = shade_q;
  assign valid_out  = valid_q;
  assign sof        = sof_q;
  assign eol        = eol_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DONE);

endmodule
